// File: rtl/prog_ctr_pkg.sv
// Shared types and constants for the program-counter stage.
// Holds the FSM state type and the branch-target table of the loaded program.
package prog_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int PC_W_DEF = 10;
    localparam int LUT_N    = 16;

    typedef logic [PC_W_DEF-1:0] lut_t [LUT_N];

    localparam lut_t BR_LUT = '{
        10'd0,   10'd16,  10'd32,  10'd40,
        10'd64,  10'd80,  10'd96,  10'd112,
        10'd128, 10'd160, 10'd192, 10'd224,
        10'd256, 10'd384, 10'd512, 10'd768
    };

endpackage

// File: rtl/prog_ctr_if.sv
// Control/status bundle between the sequencer and its driver.
// The slave side is the program counter; the master is top/bench.
interface prog_ctr_if
    import prog_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = 16
);

    logic             start;
    logic             stall;
    logic             halt;
    logic             br_en;
    logic [3:0]       br_idx;
    logic             zero_flag;
    logic [PC_W-1:0]  pc;
    logic             running;
    logic             done;
    logic             ovf_err;
    logic [CNT_W-1:0] cyc_cnt;

    modport master (
        output start, stall, halt, br_en, br_idx, zero_flag,
        input  pc, running, done, ovf_err, cyc_cnt
    );

    modport slave (
        input  start, stall, halt, br_en, br_idx, zero_flag,
        output pc, running, done, ovf_err, cyc_cnt
    );

endinterface

// File: rtl/prog_ctr_br_lut.sv
// Branch-target lookup: 4-bit index to a PC_W-bit target address.
// Entries come from the program table and are sized to the PC width.
module br_lut
    import prog_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [3:0]      idx,
    output logic [PC_W-1:0] tgt
);

    logic [PC_W_DEF-1:0] raw;

    // Table read, then resize (zero-extend or trim) to the pc width
    always_comb begin
        raw = BR_LUT[idx];
        tgt = PC_W'(raw);
    end

endmodule

// File: rtl/prog_ctr.sv
// Program counter and run sequencer in front of the ALU.
// Steps, branches or halts each cycle and counts cycles spent running.
module prog_ctr
    import prog_pkg::*;
#(
    parameter int          PC_W     = PC_W_DEF,
    parameter int unsigned START_PC = 0,
    parameter int          CNT_W    = 16
) (
    input  logic     clk,
    input  logic     reset_n,
    prog_ctr_if.slave bus
);

    localparam logic [PC_W-1:0]  PC_MAX  = '1;
    localparam logic [PC_W-1:0]  PC_INIT = PC_W'(START_PC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             armed_q, armed_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  br_tgt;

    br_lut #(.PC_W(PC_W)) u_lut (
        .idx (bus.br_idx),
        .tgt (br_tgt)
    );

    // State and datapath registers; reset aborts any run at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= PC_INIT;
            armed_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            armed_q <= armed_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: arm on start, run with stall > halt > branch > step
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        armed_d = armed_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pc_d    = PC_INIT;
                    armed_d = 1'b1;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else if (armed_q) begin
                    state_d = RUN;
                    armed_d = 1'b0;
                end
            end
            RUN: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (bus.stall) begin
                    state_d = RUN;
                end else if (bus.halt) begin
                    state_d = DONE;
                end else if (bus.br_en && bus.zero_flag) begin
                    pc_d = br_tgt;
                end else if (pc_q == PC_MAX) begin
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d = IDLE;
                    pc_d    = PC_INIT;
                    armed_d = 1'b1;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                armed_d = 1'b0;
            end
        endcase
    end

    assign bus.pc      = pc_q;
    assign bus.running = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.ovf_err = ovf_q;
    assign bus.cyc_cnt = cnt_q;

endmodule

// File: tb/tb_prog_ctr.sv
// Scoreboard bench for prog_ctr: directed steps queue expectations,
// a monitor pops one per cycle and compares against the chosen DUT.
module tb_prog_ctr;

    import prog_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    bit   rn_drv = 1'b0;

    always #5 clk = ~clk;

    prog_ctr_if #(.PC_W(10), .CNT_W(16)) ia ();
    prog_ctr_if #(.PC_W(4),  .CNT_W(3))  ib ();

    prog_ctr #(.PC_W(10), .START_PC(0), .CNT_W(16)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ia.slave)
    );

    prog_ctr #(.PC_W(4), .START_PC(14), .CNT_W(3)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ib.slave)
    );

    typedef struct {
        int    sel;
        int    pc;
        bit    run;
        bit    done;
        bit    ovf;
        int    cyc;
        string name;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cur_pc = 0;
    int   cur_cyc = 0;

    task automatic drive(input int sel, input bit st, input bit sl,
                         input bit h, input bit b,
                         input logic [3:0] idx, input bit z);
        ia.start = 0; ia.stall = 0; ia.halt = 0;
        ia.br_en = 0; ia.br_idx = 0; ia.zero_flag = 0;
        ib.start = 0; ib.stall = 0; ib.halt = 0;
        ib.br_en = 0; ib.br_idx = 0; ib.zero_flag = 0;
        if (sel == 0) begin
            ia.start = st; ia.stall = sl; ia.halt = h;
            ia.br_en = b; ia.br_idx = idx; ia.zero_flag = z;
        end else begin
            ib.start = st; ib.stall = sl; ib.halt = h;
            ib.br_en = b; ib.br_idx = idx; ib.zero_flag = z;
        end
    endtask

    task automatic step(input int sel, input bit st, input bit sl,
                        input bit h, input bit b,
                        input logic [3:0] idx, input bit z,
                        input int epc, input bit er, input bit ed,
                        input bit eo, input int ec, input string nm);
        exp_t e;
        @(negedge clk);
        reset_n = rn_drv;
        drive(sel, st, sl, h, b, idx, z);
        e = '{sel: sel, pc: epc, run: er, done: ed,
              ovf: eo, cyc: ec, name: nm};
        sbq.push_back(e);
    endtask

    task automatic inc_a(input int n);
        for (int i = 0; i < n; i++) begin
            cur_pc++;
            cur_cyc++;
            step(0, 0, 0, 0, 0, 4'd0, 0, cur_pc, 1, 0, 0, cur_cyc, "inc");
        end
    endtask

    task automatic arm_a(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 1, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, "arm");
        end
        step(0, 0, 0, 0, 0, 4'd0, 0, 0, 1, 0, 0, 0, "run_first");
        cur_pc = 0;
        cur_cyc = 0;
    endtask

    // Monitor: one expectation per clock, sampled just after the edge
    initial begin
        exp_t e;
        int   apc, acyc;
        bit   arun, adone, aovf;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.sel == 0) begin
                    apc = int'(ia.pc); acyc = int'(ia.cyc_cnt);
                    arun = ia.running; adone = ia.done; aovf = ia.ovf_err;
                end else begin
                    apc = int'(ib.pc); acyc = int'(ib.cyc_cnt);
                    arun = ib.running; adone = ib.done; aovf = ib.ovf_err;
                end
                n_chk++;
                if (apc == e.pc && arun == e.run && adone == e.done &&
                    aovf == e.ovf && acyc == e.cyc) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s dut%0d: got pc=%0d run=%0b done=%0b ovf=%0b cyc=%0d want pc=%0d run=%0b done=%0b ovf=%0b cyc=%0d",
                             e.name, e.sel, apc, arun, adone, aovf, acyc,
                             e.pc, e.run, e.done, e.ovf, e.cyc);
                end
            end
        end
    end

    initial begin
        int guard;
        drive(0, 0, 0, 0, 0, 4'd0, 0);
        rn_drv = 0;
        step(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, "reset");
        rn_drv = 1;
        step(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, "idle");

        arm_a(2);
        inc_a(5);
        step(0, 0, 0, 1, 0, 4'd0, 0, 5, 0, 1, 0, 6, "halt5");
        step(0, 0, 0, 0, 0, 4'd0, 0, 5, 0, 1, 0, 6, "done_hold");

        arm_a(1);
        inc_a(7);
        step(0, 0, 0, 0, 1, 4'd3, 1, 40, 1, 0, 0, 8, "br_taken");
        step(0, 0, 0, 1, 0, 4'd0, 0, 40, 0, 1, 0, 9, "halt40");

        arm_a(1);
        inc_a(7);
        step(0, 0, 0, 0, 1, 4'd3, 0, 8, 1, 0, 0, 8, "br_not_taken");
        cur_pc = 8;
        cur_cyc = 8;
        inc_a(2);
        step(0, 0, 1, 1, 0, 4'd0, 0, 10, 1, 0, 0, 11, "stall1");
        step(0, 0, 1, 1, 1, 4'd3, 1, 10, 1, 0, 0, 12, "stall2");
        step(0, 0, 1, 1, 0, 4'd0, 0, 10, 1, 0, 0, 13, "stall3");
        step(0, 0, 0, 1, 0, 4'd0, 0, 10, 0, 1, 0, 14, "stall_release");

        arm_a(1);
        inc_a(2);
        step(0, 0, 0, 1, 1, 4'd3, 1, 2, 0, 1, 0, 3, "halt_vs_br");

        arm_a(1);
        inc_a(3);
        step(0, 1, 0, 0, 0, 4'd0, 0, 4, 1, 0, 0, 4, "start_in_run");
        cur_pc = 4;
        cur_cyc = 4;
        inc_a(16);
        rn_drv = 0;
        step(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, "mid_reset");
        rn_drv = 1;
        step(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, "post_reset");
        arm_a(1);
        inc_a(1);

        step(1, 1, 0, 0, 0, 4'd0, 0, 14, 0, 0, 0, 0, "b_arm");
        step(1, 0, 0, 0, 0, 4'd0, 0, 14, 1, 0, 0, 0, "b_run");
        step(1, 0, 0, 0, 0, 4'd0, 0, 15, 1, 0, 0, 1, "b_pc15");
        step(1, 0, 0, 0, 0, 4'd0, 0, 15, 0, 1, 1, 2, "b_ovf");
        step(1, 0, 0, 0, 0, 4'd0, 0, 15, 0, 1, 1, 2, "b_ovf_hold");
        step(1, 1, 0, 0, 0, 4'd0, 0, 14, 0, 0, 0, 0, "b_rearm");
        step(1, 0, 0, 0, 0, 4'd0, 0, 14, 1, 0, 0, 0, "b_run2");
        for (int i = 1; i <= 9; i++) begin
            step(1, 0, 1, 0, 0, 4'd0, 0, 14, 1, 0, 0,
                 (i > 7) ? 7 : i, "b_sat");
        end
        step(1, 0, 0, 0, 0, 4'd0, 0, 15, 1, 0, 0, 7, "b_sat_hold");
        step(1, 0, 0, 0, 0, 4'd0, 0, 15, 0, 1, 1, 7, "b_ovf2");

        guard = 0;
        while (sbq.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (sbq.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d entries left, want 0", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
